conv_result_writer: RTL
=======================

# conv_result_writer

Write-back end of the convolution path. It accepts 20-bit results from the convolution engine one at a time and normalises each by the kernel weight sum (16). It then saturates the value to 8 bits and writes it, raster-ordered, into the output block RAM port A (`wea`/`addra`/`dina`). It sits between the convolution unit's `result`/done output and the output BRAM, mirroring the read-side FSM that fetches pixels from the input BRAM.

## Interface
Parameters:
- `OUT_W`, 126: output image width in pixels (input width minus 2).
- `OUT_H`, 126: output image height in pixels.
- `OUT_BASE`, 15'h0000: BRAM address of the first output pixel.
- `NORM_SHIFT`, 4: right shift applied to each result (kernel sum 16).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `frame_start`, input, 1: one-cycle pulse that arms the writer for a new frame.
- `res_valid`, input, 1: result present on `res_data`; driven from the convolution done pulse.
- `res_data`, input, 20: unsigned convolution result.
- `res_ready`, output, 1: writer will accept a result this cycle.
- `wea`, output, 1: BRAM write enable, one cycle per pixel.
- `addra`, output, 15: BRAM write address.
- `dina`, output, 8: BRAM write data.
- `busy`, output, 1: high from arming until `frame_done`.
- `frame_done`, output, 1: one-cycle pulse after the last pixel write.
- `sat_count`, output, 16: number of saturated pixels in the current frame; sticks at 16'hFFFF.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE → RUN on `frame_start`.
  - Entering RUN clears the column counter, row counter, `sat_count` and the address register (address register ← `OUT_BASE`).
- In RUN, `res_ready` = 1. Accept = `res_valid` && `res_ready`.
- On each accept:
  - Compute `pix` = `res_data` >> `NORM_SHIFT`.
  - If `pix` > 255, write 8'hFF and increment `sat_count` (saturating); otherwise write `pix`[7:0].
  - Register `wea`=1, `addra`=current address, `dina`=pixel.
  - Increment the address. The column counter wraps at `OUT_W`-1 and increments the row counter on wrap.
- The last accept is the one at column `OUT_W`-1, row `OUT_H`-1. On it, the state goes to DONE.
- DONE asserts `frame_done` for one cycle, then goes unconditionally to IDLE.
- `frame_start` in RUN or DONE is ignored; the frame in progress is not restarted.
- In IDLE and DONE, `res_ready` = 0. A `res_valid` in those states is not accepted and nothing is written.
- `busy` = (state != IDLE).
- Addresses are 15-bit modular. `OUT_BASE` + `OUT_W`*`OUT_H` beyond 32767 wraps to 0; no error flag is raised.
- Reset mid-frame: all state is cleared immediately and asynchronously, and no further writes occur until the next `frame_start`.

## Timing
- Reset values:
  - State is IDLE.
  - `res_ready`, `wea`, `busy` and `frame_done` are 0.
  - `addra` and `dina` are 0; `sat_count` is 0.
  - The column, row and address registers are 0.
- All outputs are registered except `res_ready` and `busy`, which decode the state register directly.
- `frame_start` sampled at edge t: `busy` and `res_ready` go high after edge t. The first accept is possible at edge t+1.
- Accept sampled at edge k: `wea`, `addra` and `dina` are valid in the cycle after edge k, for exactly one cycle unless a further accept occurs at edge k+1.
- Back-to-back accepts on every edge are allowed. Throughput is 1 pixel/cycle and latency is 1 cycle.
- Last accept at edge k:
  - `wea` is high in cycle k+1, and `res_ready` drops after edge k.
  - `frame_done` is high in cycle k+1 (state DONE), coincident with the last `wea`, then low.
  - `busy` falls after edge k+1.
- A `frame_start` coincident with the `frame_done` cycle is ignored. A `frame_start` one cycle later arms a new frame.

## Test plan
Test parameters for scenarios 1–4 and 6: `OUT_W`=3, `OUT_H`=2, `OUT_BASE`=15'h4000.
- **Reset:** assert `rst_n`=0 mid-clock → all outputs 0 immediately. Release it and drive `res_valid`=1 without `frame_start` → `wea` never asserts and `res_ready` stays 0.
- **Full frame, back-to-back:** `frame_start`, then 6 consecutive accepts of `res_data` = 16, 32, 4080, 4096, 0, 20'hFFFFF.
  - Writes are (4000,01), (4001,02), (4002,FF), (4003,FF), (4004,00), (4005,FF).
  - `sat_count`=2. `frame_done` is high in the same cycle as the 4005 write.
- **Gapped input:** same frame with `res_valid` asserted every 5th cycle → identical write sequence, one `wea` per accept, and `busy` held high throughout.
- **Restart ignored:** pulse `frame_start` after the 3rd accept → the address continues at 4003 and a single `frame_done` occurs after the 6th accept.
- **Reset mid-frame:** pulse `rst_n` low after 2 accepts, then `frame_start` and 6 accepts → writes restart at 4000. `sat_count` counts the new frame only.
- **Address wrap:** with `OUT_BASE`=15'h7FFE, `OUT_W`=2, `OUT_H`=2, run 4 accepts → addresses 7FFE, 7FFF, 0000, 0001, then `frame_done`.

Source files
------------

// File: rtl/conv_result_writer.sv
// conv_result_writer: normalises 20-bit convolution results by >> NORM_SHIFT,
// saturates them to 8 bits and writes them raster-ordered into BRAM port A.
// Latency: 1 cycle from accept to wea/addra/dina. Throughput: 1 pixel/cycle.
// Backpressure: res_ready is high only in RUN. A res_valid in IDLE/DONE is dropped.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   frame_start                one-cycle pulse that arms a frame (only honoured in IDLE)
//   res_valid/res_data/res_ready  result handshake from the convolution unit
//   wea/addra/dina             BRAM port A write (registered)
//   busy                       state != IDLE (decoded from state)
//   frame_done                 one-cycle pulse coincident with the last write
//   sat_count                  saturated-pixel count for the current frame, sticks at FFFF
module conv_result_writer #(
    parameter int          OUT_W      = 126,
    parameter int          OUT_H      = 126,
    parameter logic [14:0] OUT_BASE   = 15'h0000,
    parameter int          NORM_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        res_valid,
    input  logic [19:0] res_data,
    output logic        res_ready,
    output logic        wea,
    output logic [14:0] addra,
    output logic [7:0]  dina,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] sat_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 16-bit counters cover any image that fits the 15-bit address space.
    localparam logic [15:0] COL_MAX = 16'(OUT_W - 1);
    localparam logic [15:0] ROW_MAX = 16'(OUT_H - 1);

    state_t      state_q, state_d;
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] sat_q, sat_d;
    logic        wea_q, wea_d;
    logic [14:0] addra_q, addra_d;
    logic [7:0]  dina_q, dina_d;
    logic        done_q, done_d;

    logic        accept;
    logic [19:0] pix;
    logic        pix_sat;

    always_comb begin
        accept  = (state_q == RUN) && res_valid;
        pix     = res_data >> NORM_SHIFT;
        // Anything at or above 256 after normalisation does not fit in 8 bits.
        pix_sat = |pix[19:8];

        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        sat_d   = sat_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dina_d  = dina_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = RUN;
                    col_d   = 16'd0;
                    row_d   = 16'd0;
                    sat_d   = 16'd0;
                    addr_d  = OUT_BASE;
                end
            end
            RUN: begin
                if (accept) begin
                    wea_d   = 1'b1;
                    addra_d = addr_q;
                    dina_d  = pix_sat ? 8'hFF : pix[7:0];
                    if (pix_sat && (sat_q != 16'hFFFF)) begin
                        sat_d = sat_q + 16'd1;
                    end
                    // 15-bit modular: a frame running past 7FFF wraps to 0.
                    addr_d = addr_q + 15'd1;
                    if (col_q == COL_MAX) begin
                        col_d = 16'd0;
                        row_d = row_q + 16'd1;
                        if (row_q == ROW_MAX) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            DONE: begin
                // frame_start here is deliberately ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 16'd0;
            row_q   <= 16'd0;
            addr_q  <= 15'd0;
            sat_q   <= 16'd0;
            wea_q   <= 1'b0;
            addra_q <= 15'd0;
            dina_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            sat_q   <= sat_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            done_q  <= done_d;
        end
    end

    assign res_ready  = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign frame_done = done_q;
    assign sat_count  = sat_q;

endmodule
